// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// The state encoding is shared so checkers and benches can name states.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLLRST    = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } sup_state_e;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 50000;
   localparam int DEF_STABLE_CYCLES  = 5000;
   localparam int DEF_MAX_RETRIES    = 3;
   localparam int LOCK_LOSS_MAX      = 255;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the local clock.
// Both stages clear to 0 on synchronous reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Metastability stage followed by the settled output stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, releases the outclk-domain
// reset, and retries or faults when lock cannot be obtained.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   sup_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic [7:0]       llc_q, llc_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic             locked_s;

   sync_2ff u_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   // Next-state, counter and status-counter logic; outputs decoded from state_d
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      llc_d   = llc_q;
      case (state_q)
         PLLRST: begin
            if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            else                                     state_d = PLLRST;
         end
         WAIT_LOCK: begin
            // Lock is checked first so it wins over a simultaneous timeout
            if (locked_s) begin
               state_d = STABLE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (retry_q == 2'(MAX_RETRIES)) begin
                  state_d = FAULT;
               end else begin
                  state_d = PLLRST;
                  retry_d = retry_q + 2'd1;
               end
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               retry_d = 2'd0;
            end else begin
               state_d = STABLE;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d = PLLRST;
               if (llc_q != 8'(LOCK_LOSS_MAX)) llc_d = llc_q + 8'd1;
               else                            llc_d = llc_q;
            end else begin
               state_d = RUN;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = PLLRST;
         end
      endcase

      if (state_d != state_q)                    cnt_d = {CNT_W{1'b0}};
      else if (state_q == RUN || state_q == FAULT) cnt_d = cnt_q;
      else                                       cnt_d = cnt_q + CNT_W'(1);

      pll_rst_d = (state_d == PLLRST) || (state_d == FAULT);
      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   // State, counters and registered outputs share one synchronous reset
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= PLLRST;
         cnt_q     <= {CNT_W{1'b0}};
         retry_q   <= 2'd0;
         llc_q     <= 8'd0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         llc_q     <= llc_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst       = sys_rst_q;
   assign ready         = ready_q;
   assign fault         = fault_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = llc_q;

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is refclk (50 MHz) and the reset is rst, synchronous and active-high.
REQ-002 Parameter PLL_RST_CYCLES, default 16, SHALL set the pll_rst pulse width in refclk cycles.
REQ-003 Parameter LOCK_TIMEOUT, default 50000, SHALL set the maximum cycles spent waiting for lock per attempt.
REQ-004 Parameter STABLE_CYCLES, default 5000, SHALL set the consecutive locked cycles required before release.
REQ-005 Parameter MAX_RETRIES, default 3, SHALL set the number of re-resets after a timeout before fault.
REQ-006 refclk  in  1  free-running reference clock, the same clock that feeds the PLL.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
REQ-009 pll_rst  out  1  active-high reset to the PLL.
REQ-010 sys_rst  out  1  active-high reset to the outclk-domain logic; high whenever not in RUN.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  sticky; lock was not achieved after all retries.
REQ-013 retry_cnt  out  2  number of timeout retries in the current attempt sequence.
REQ-014 lock_loss_cnt  out  8  count of RUN-state lock losses, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; locked_s denotes its output, and only locked_s is used.
REQ-016 The FSM SHALL have exactly these states: PLLRST, WAIT_LOCK, STABLE, RUN, FAULT.
REQ-017 PLLRST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK with the cycle counter cleared.
REQ-018 WAIT_LOCK: locked_s=1 SHALL move the FSM to STABLE with the counter cleared.
REQ-019 WAIT_LOCK: if LOCK_TIMEOUT cycles elapse with locked_s=0, the FSM SHALL go to FAULT when retry_cnt==MAX_RETRIES; otherwise it SHALL increment retry_cnt and go to PLLRST.
REQ-020 STABLE: locked_s=0 SHALL return the FSM to WAIT_LOCK with the counter cleared; this is not a retry and the timeout restarts.
REQ-021 STABLE: STABLE_CYCLES consecutive cycles of locked_s=1 SHALL move the FSM to RUN.
REQ-022 Entering RUN SHALL clear retry_cnt.
REQ-023 RUN: locked_s=0 SHALL move the FSM to PLLRST and increment lock_loss_cnt (saturating at 255).
REQ-024 FAULT: pll_rst=1, sys_rst=1, fault=1; the FSM SHALL stay in FAULT until rst.
REQ-025 All outputs SHALL be registered and glitch-free, and SHALL change in the same cycle as the state register.
REQ-026 From pll_locked falling in RUN to sys_rst=1, latency SHALL be at most 3 refclk cycles.
REQ-027 The counter SHALL be wide enough for max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES), and SHALL be cleared on every state change.
REQ-028 When locked_s rises on the same cycle the timeout expires in WAIT_LOCK, lock SHALL win and the FSM SHALL go to STABLE.

Reset
REQ-029 On rst the block SHALL set: state=PLLRST, counter=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0.
REQ-030 rst asserted in any state, including FAULT and mid-count, SHALL restore the REQ-029 values on the next edge, and the full sequence SHALL restart.

Structure
REQ-031 A shared package pll_sup_pkg SHALL hold the state enum and the default parameter constants.
REQ-032 The synchronizer SHALL be the single sub-module sync_2ff, 1 bit wide with reset value 0.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-033 Release rst, raise pll_locked 10 cycles later and hold it -> pll_rst high for the first 4 cycles; sys_rst falls and ready rises 2+8 cycles after pll_locked rises (±1); fault=0.
REQ-034 Hold pll_locked=0 -> three pll_rst pulses of 4 cycles each; retry_cnt goes 1 then 2; fault=1 after 3×(4+16) cycles; fault stays set; rst clears it.
REQ-035 In STABLE, drive locked high for 5 cycles, low for 1 cycle, then high -> sys_rst stays 1; retry_cnt unchanged; RUN is reached 8 stable cycles after the re-rise.
REQ-036 In RUN, drop pll_locked -> sys_rst=1 and ready=0 within 3 cycles; one 4-cycle pll_rst pulse; lock_loss_cnt=1; re-lock returns the FSM to RUN.
REQ-037 Cause 300 RUN lock losses -> lock_loss_cnt=255.
REQ-038 Assert rst mid-STABLE and again in FAULT -> all outputs equal the REQ-029 values on the next edge.
